mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, 32, width of data_addr_in.
REQ-002 SHALL have parameter IDX_W, 10, line-index bits; the array holds 2^IDX_W 64-bit lines.
REQ-003 SHALL have parameter RD_LAT, 3, cycles from read acceptance to rdata_valid_out; legal range 1..15.
REQ-004 SHALL have parameter WR_LAT, 2, cycles from write acceptance to wdata_ready_out; legal range 1..15.
REQ-005 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rstn  in  1  synchronous, active-high reset (1 = reset), sampled on the clk rising edge.
REQ-007 SHALL have port data_addr_in  in  ADDR_W  byte address of the request.
REQ-008 SHALL have port rdata_en_in  in  1  read request level, held high by the initiator until it sees rdata_valid_out.
REQ-009 SHALL have port wdata_en_in  in  1  write request level, held high by the initiator until it sees wdata_ready_out.
REQ-010 SHALL have port wdata_in  in  64  write data, LSB-justified.
REQ-011 SHALL have port wlen_in  in  2  write size: 00 byte, 01 half, 10 word, 11 dword.
REQ-012 SHALL have port rdata_out  out  64  full cache line read.
REQ-013 SHALL have port rdata_valid_out  out  1  single-cycle read-complete pulse.
REQ-014 SHALL have port wdata_ready_out  out  1  single-cycle write-complete pulse.

Function
REQ-015 SHALL implement FSM states IDLE, RD_WAIT, WR_WAIT, TURN.
REQ-016 IDLE SHALL accept a request on a clk edge where rdata_en_in or wdata_en_in is 1, latching data_addr_in, wdata_in and wlen_in, and loading a 4-bit latency counter.
REQ-017 If rdata_en_in and wdata_en_in are both 1 in IDLE, the read SHALL be accepted and the write left pending, to be accepted on the next pass through IDLE.
REQ-018 Line index SHALL be addr[IDX_W+2:3]; addr[2:0] SHALL be ignored for reads; address bits above IDX_W+2 SHALL be ignored (aliasing wrap).
REQ-019 A read accepted at edge N SHALL pulse rdata_valid_out high for exactly the cycle after edge N+RD_LAT-1, i.e. RD_LAT cycles after acceptance.
REQ-020 rdata_out SHALL be the line contents at the latched index, updated at the same edge that raises rdata_valid_out, and held unchanged until the next read completes.
REQ-021 A write accepted at edge N SHALL commit to the array and pulse wdata_ready_out high for exactly one cycle, with both taking effect at edge N+WR_LAT.
REQ-022 Write byte lanes SHALL be: byte, lane addr[2:0]; half, lanes {addr[2:1],0}+0..1; word, lanes {addr[2],00}+0..3; dword, all 8 lanes.
REQ-023 Low address bits below the access size SHALL be ignored (align-down); data SHALL be taken from wdata_in LSBs and shifted into those lanes; other lanes SHALL be unchanged.
REQ-024 Latched request fields SHALL govern the whole transaction; input changes or en deassertion mid-flight SHALL NOT abort or alter it.
REQ-025 After each valid/ready pulse the FSM SHALL enter TURN for one cycle, ignore requests, then return to IDLE.
REQ-026 Minimum issue rate SHALL be one transaction per LAT+2 cycles.
REQ-027 rdata_valid_out and wdata_ready_out SHALL never be high in the same cycle.
REQ-028 A read issued after a write to the same line has completed SHALL return the written data.

Reset
REQ-029 While rstn=1 at an edge: FSM to IDLE, counter 0, rdata_valid_out 0, wdata_ready_out 0, rdata_out 0.
REQ-030 Reset mid-transaction SHALL drop it with no pulse; a write not yet committed SHALL NOT modify the array.
REQ-031 Array contents SHALL NOT be reset; they are undefined until written.

Verification
REQ-032 Write dword 0x1122334455667788 @0x40, then read @0x44 -> ready pulse 2 cycles after accept; valid 3 cycles after accept, rdata_out=0x1122334455667788.
REQ-033 Over that line: byte 0xAA @0x43, half 0xBBCC @0x45, word 0xDEADBEEF @0x40 -> read @0x40 returns 0x1122BBCCDEADBEEF.
REQ-034 rdata_en_in and wdata_en_in high together in IDLE -> read served first; write ready pulses only after TURN; each pulse exactly 1 cycle.
REQ-035 Reset asserted 1 cycle after accepting a write of 0xFF dword @0x80 -> no ready pulse; a later read @0x80 returns the prior contents.
REQ-036 Read @0x40 then read @(0x40 + 2^(IDX_W+3)) -> identical data (alias); rdata_out holds between pulses.

Source files
------------

// File: rtl/mem_responder.sv
// Single-port 64-bit line memory answering one read or write at a time
// with fixed, parameterised completion latencies.
module mem_responder #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 10,
    parameter int RD_LAT = 3,
    parameter int WR_LAT = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] data_addr_in,
    input  logic              rdata_en_in,
    input  logic              wdata_en_in,
    input  logic [63:0]       wdata_in,
    input  logic [1:0]        wlen_in,
    output logic [63:0]       rdata_out,
    output logic              rdata_valid_out,
    output logic              wdata_ready_out
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, TURN} state_t;

    localparam logic [3:0] RD_LOAD = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_LAT);

    state_t           state;
    logic [3:0]       cnt;
    logic [IDX_W+2:0] addr_q;
    logic [63:0]      wdata_q;
    logic [1:0]       wlen_q;

    logic [63:0]      mem [2**IDX_W];

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_in;
    logic [2:0]       lane_off;
    logic [7:0]       size_mask;
    logic [7:0]       byte_en;
    logic [63:0]      wdata_sh;
    logic             commit;
    logic             unused_addr_hi;

    assign idx_q          = addr_q[IDX_W+2:3];
    assign idx_in         = data_addr_in[IDX_W+2:3];
    assign unused_addr_hi = ^data_addr_in[ADDR_W-1:IDX_W+3];

    // Align the offset down to the access size, then place LSB-justified data
    always_comb begin
        lane_off  = '0;
        size_mask = '1;
        case (wlen_q)
            2'b00: begin lane_off = addr_q[2:0];                size_mask = 8'h01; end
            2'b01: begin lane_off = {addr_q[2:1], 1'b0};        size_mask = 8'h03; end
            2'b10: begin lane_off = {addr_q[2], 2'b00};         size_mask = 8'h0F; end
            default: begin lane_off = '0;                       size_mask = 8'hFF; end
        endcase
        byte_en  = size_mask << lane_off;
        wdata_sh = wdata_q << {lane_off, 3'b000};
    end

    assign commit = !rstn && (state == WR_WAIT) && (cnt == 4'd1);

    // Array is deliberately not reset; a write dropped by reset never commits
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (byte_en[b]) mem[idx_q][b*8 +: 8] <= wdata_sh[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state           <= IDLE;
            cnt             <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            wlen_q          <= '0;
            rdata_out       <= '0;
            rdata_valid_out <= 1'b0;
            wdata_ready_out <= 1'b0;
        end else begin
            rdata_valid_out <= 1'b0;
            wdata_ready_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (rdata_en_in || wdata_en_in) begin
                        addr_q  <= data_addr_in[IDX_W+2:0];
                        wdata_q <= wdata_in;
                        wlen_q  <= wlen_in;
                    end
                    if (rdata_en_in) begin
                        if (RD_LAT == 1) begin
                            rdata_out       <= mem[idx_in];
                            rdata_valid_out <= 1'b1;
                            cnt             <= '0;
                            state           <= TURN;
                        end else begin
                            cnt   <= RD_LOAD;
                            state <= RD_WAIT;
                        end
                    end else if (wdata_en_in) begin
                        cnt   <= WR_LOAD;
                        state <= WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cnt == 4'd1) begin
                        rdata_out       <= mem[idx_q];
                        rdata_valid_out <= 1'b1;
                        cnt             <= '0;
                        state           <= TURN;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_WAIT: begin
                    if (cnt == 4'd1) begin
                        wdata_ready_out <= 1'b1;
                        cnt             <= '0;
                        state           <= TURN;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                TURN:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized checks of mem_responder against a byte-level
// memory model with latency expectations derived from RD_LAT / WR_LAT.
module tb_mem_responder;

    localparam int ADDR_W = 32;
    localparam int IDX_W  = 10;
    localparam int RD_LAT = 3;
    localparam int WR_LAT = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic [ADDR_W-1:0] data_addr_in;
    logic              rdata_en_in;
    logic              wdata_en_in;
    logic [63:0]       wdata_in;
    logic [1:0]        wlen_in;
    logic [63:0]       rdata_out;
    logic              rdata_valid_out;
    logic              wdata_ready_out;

    int checks = 0;
    int errors = 0;

    logic [63:0] model [int];
    logic [63:0] last_rd;
    bit          last_known;
    logic [63:0] alias_a;

    mem_responder #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk(clk),
        .rstn(rstn),
        .data_addr_in(data_addr_in),
        .rdata_en_in(rdata_en_in),
        .wdata_en_in(wdata_en_in),
        .wdata_in(wdata_in),
        .wlen_in(wlen_in),
        .rdata_out(rdata_out),
        .rdata_valid_out(rdata_valid_out),
        .wdata_ready_out(wdata_ready_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 3) & ((32'd1 << IDX_W) - 1));
    endfunction

    function automatic logic [63:0] model_get(input logic [31:0] a);
        if (model.exists(line_of(a))) return model[line_of(a)];
        return 'x;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [63:0] d, input logic [1:0] len);
        int size;
        int base;
        logic [63:0] line;
        size = 1 << len;
        base = int'(a % 8) / size * size;
        line = model_get(a);
        for (int i = 0; i < size; i++) line[(base + i) * 8 +: 8] = d[i * 8 +: 8];
        model[line_of(a)] = line;
    endtask

    task automatic scramble();
        data_addr_in = $urandom;
        wdata_in     = {$urandom, $urandom};
        wlen_in      = 2'($urandom);
    endtask

    task automatic do_read(input logic [31:0] a);
        int lat;
        bit got;
        logic [63:0] exp;
        exp = model_get(a);
        data_addr_in = a;
        rdata_en_in  = 1'b1;
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            step();
            lat++;
            if (lat == 1) scramble();
            if (rdata_valid_out === 1'b1) got = 1;
        end
        check("rd_latency", 64'(lat), 64'(RD_LAT));
        check("rd_no_ready", {63'd0, wdata_ready_out}, 64'd0);
        if (!$isunknown(exp)) begin
            check("rd_data", rdata_out, exp);
            last_rd    = exp;
            last_known = 1;
        end else begin
            last_known = 0;
        end
        step();
        rdata_en_in = 1'b0;
        check("rd_pulse_width", {63'd0, rdata_valid_out}, 64'd0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [1:0] len);
        int lat;
        bit got;
        data_addr_in = a;
        wdata_in     = d;
        wlen_in      = len;
        wdata_en_in  = 1'b1;
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            step();
            lat++;
            if (lat == 1) scramble();
            if (wdata_ready_out === 1'b1) got = 1;
        end
        check("wr_latency", 64'(lat), 64'(WR_LAT + 1));
        check("wr_no_valid", {63'd0, rdata_valid_out}, 64'd0);
        model_write(a, d, len);
        step();
        wdata_en_in = 1'b0;
        check("wr_pulse_width", {63'd0, wdata_ready_out}, 64'd0);
        if (last_known) check("rdata_hold", rdata_out, last_rd);
    endtask

    task automatic do_both(input logic [31:0] a, input logic [63:0] d, input logic [1:0] len);
        int lat;
        bit got;
        logic [63:0] exp;
        exp = model_get(a);
        data_addr_in = a;
        wdata_in     = d;
        wlen_in      = len;
        rdata_en_in  = 1'b1;
        wdata_en_in  = 1'b1;
        lat = 0;
        got = 0;
        while (!got && lat < 60) begin
            step();
            lat++;
            if (rdata_valid_out === 1'b1) got = 1;
        end
        check("both_rd_latency", 64'(lat), 64'(RD_LAT));
        check("both_rd_data", rdata_out, exp);
        check("both_rd_no_ready", {63'd0, wdata_ready_out}, 64'd0);
        step();
        lat++;
        rdata_en_in = 1'b0;
        check("both_rd_pulse_width", {63'd0, rdata_valid_out}, 64'd0);
        got = 0;
        while (!got && lat < 60) begin
            step();
            lat++;
            if (wdata_ready_out === 1'b1) got = 1;
        end
        check("both_wr_latency", 64'(lat), 64'(RD_LAT + 2 + WR_LAT));
        check("both_wr_no_valid", {63'd0, rdata_valid_out}, 64'd0);
        model_write(a, d, len);
        last_rd    = exp;
        last_known = 1;
        step();
        wdata_en_in = 1'b0;
        check("both_wr_pulse_width", {63'd0, wdata_ready_out}, 64'd0);
    endtask

    initial begin
        bit saw;
        rstn         = 1'b1;
        data_addr_in = '0;
        rdata_en_in  = 1'b0;
        wdata_en_in  = 1'b0;
        wdata_in     = '0;
        wlen_in      = '0;
        last_known   = 0;
        last_rd      = '0;
        repeat (3) step();
        check("rst_valid", {63'd0, rdata_valid_out}, 64'd0);
        check("rst_ready", {63'd0, wdata_ready_out}, 64'd0);
        check("rst_rdata", rdata_out, 64'd0);
        rstn = 1'b0;
        step();

        do_write(32'h40, 64'h1122334455667788, 2'b11);
        do_read(32'h44);
        check("dword_const", rdata_out, 64'h1122334455667788);

        do_write(32'h43, 64'h00000000000000AA, 2'b00);
        do_write(32'h45, 64'h000000000000BBCC, 2'b01);
        do_write(32'h40, 64'h00000000DEADBEEF, 2'b10);
        do_read(32'h40);
        check("merge_const", rdata_out, 64'h1122BBCCDEADBEEF);

        do_write(32'h48, 64'hCAFEF00D12345678, 2'b11);
        do_both(32'h48, 64'h0BADC0DE0BADC0DE, 2'b11);
        do_read(32'h48);

        do_write(32'h80, 64'h0123456789ABCDEF, 2'b11);
        data_addr_in = 32'h80;
        wdata_in     = '1;
        wlen_in      = 2'b11;
        wdata_en_in  = 1'b1;
        step();
        rstn        = 1'b1;
        wdata_en_in = 1'b0;
        step();
        rstn = 1'b0;
        check("midrst_rdata", rdata_out, 64'd0);
        last_rd    = '0;
        last_known = 1;
        saw = 0;
        repeat (6) begin
            step();
            if (wdata_ready_out !== 1'b0) saw = 1;
        end
        check("midrst_no_ready", {63'd0, saw}, 64'd0);
        do_read(32'h80);
        check("midrst_const", rdata_out, 64'h0123456789ABCDEF);

        do_read(32'h40);
        alias_a = rdata_out;
        do_read(32'h40 + (32'd1 << (IDX_W + 3)));
        check("alias_equal", rdata_out, alias_a);

        for (int i = 0; i < 16; i++) do_write(32'(i * 8), {$urandom, $urandom}, 2'b11);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 127)) | (32'($urandom_range(0, 3)) << (IDX_W + 3));
            if ($urandom_range(0, 1) == 0) do_read(a);
            else do_write(a, {$urandom, $urandom}, 2'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
